// File: rtl/muldiv_pkg.sv
// muldiv_pkg: shared definitions for the iterative multiply/divide unit.
//   - WIDTH_DEF      default operand width (HI/LO are WIDTH bits each)
//   - OP_*           op encodings as issued by EX
//   - state_t        sequencer states (IDLE, RUN, FIX)
//   - op_is_div/op_is_signed  small decode helpers
package muldiv_pkg;

   localparam int WIDTH_DEF = 32;

   localparam logic [1:0] OP_MULT  = 2'b00;
   localparam logic [1:0] OP_MULTU = 2'b01;
   localparam logic [1:0] OP_DIV   = 2'b10;
   localparam logic [1:0] OP_DIVU  = 2'b11;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      FIX  = 2'd2
   } state_t;

   // op[1] selects divide; op[0] selects unsigned.
   function automatic logic op_is_div(input logic [1:0] op);
      return op[1];
   endfunction

   function automatic logic op_is_signed(input logic [1:0] op);
      return ~op[0];
   endfunction

endpackage

// File: rtl/muldiv_unit_if.sv
// muldiv_unit_if: EX-side bundle of the multiply/divide unit.
//   master (EX / hazard side): drives start, op, a, b, mthi, mtlo, flush;
//                              observes hi, lo, busy, done.
//   slave  (muldiv_unit)     : the reverse.
// Handshake: start is a single-cycle issue strobe. The unit has no separate
// ready; it accepts start only when busy=0 and flush=0 at the sampling edge,
// and silently drops a start seen while busy. done pulses for one cycle in the
// cycle after the edge that wrote HI/LO for an op (never for mthi/mtlo).
interface muldiv_unit_if
   import muldiv_pkg::*;
#(
   parameter int WIDTH = WIDTH_DEF
) ();

   logic             start;
   logic [1:0]       op;
   logic [WIDTH-1:0] a;
   logic [WIDTH-1:0] b;
   logic             mthi;
   logic             mtlo;
   logic             flush;
   logic [WIDTH-1:0] hi;
   logic [WIDTH-1:0] lo;
   logic             busy;
   logic             done;

   modport master (
      output start, op, a, b, mthi, mtlo, flush,
      input  hi, lo, busy, done
   );

   modport slave (
      input  start, op, a, b, mthi, mtlo, flush,
      output hi, lo, busy, done
   );

endinterface

// File: rtl/div_core.sv
// div_core: one combinational restoring-division step.
//   rem_in  partial remainder (WIDTH)
//   quo_in  quotient register; its MSB is the next dividend bit shifted in
//   dvs     divisor magnitude (WIDTH)
//   rem_out next partial remainder
//   quo_out quo_in shifted left with the new quotient bit in the LSB
module div_core
   import muldiv_pkg::*;
#(
   parameter int WIDTH = WIDTH_DEF
) (
   input  logic [WIDTH-1:0] rem_in,
   input  logic [WIDTH-1:0] quo_in,
   input  logic [WIDTH-1:0] dvs,
   output logic [WIDTH-1:0] rem_out,
   output logic [WIDTH-1:0] quo_out
);

   logic [WIDTH:0]   shifted;
   logic [WIDTH-1:0] diff;
   logic             fits;

   always_comb begin
      shifted = {rem_in, quo_in[WIDTH-1]};
      fits    = (shifted >= {1'b0, dvs});
      // When the divisor fits, the true difference is below dvs and therefore
      // below 2^WIDTH, so the low WIDTH bits of the subtraction are exact.
      diff    = shifted[WIDTH-1:0] - dvs;
      rem_out = fits ? diff : shifted[WIDTH-1:0];
      quo_out = {quo_in[WIDTH-2:0], fits};
   end

endmodule

// File: rtl/muldiv_unit.sv
// muldiv_unit: iterative MULT/MULTU/DIV/DIVU unit with HI/LO registers.
// Ports:
//   clk        rising-edge clock
//   rst        asynchronous, active-low reset
//   bus        muldiv_unit_if.slave (start/op/a/b/mthi/mtlo/flush in,
//              hi/lo/busy/done out)
//   dbg_state  current sequencer state
// Operation: the issue edge latches operand magnitudes and result signs,
// RUN performs WIDTH shift-add or restoring shift-subtract iterations, FIX
// applies the sign correction and writes HI/LO. Divide by zero writes
// lo=all-ones, hi=a at the issue edge without iterating.
// Optional build macro MULDIV_FAST_MUL_EN: multiplies complete at the issue
// edge through a combinational WIDTHxWIDTH multiplier; divides are unchanged.
module muldiv_unit
   import muldiv_pkg::*;
#(
   parameter int WIDTH = WIDTH_DEF
) (
   input  logic   clk,
   input  logic   rst,
   muldiv_unit_if.slave bus,
   output state_t dbg_state
);

   localparam int MSB = WIDTH - 1;
   localparam int CW  = $clog2(WIDTH);
   localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

   state_t             state;
   logic [CW-1:0]      cnt;
   logic               is_div_q;
   logic               neg_lo_q;   // product sign (mul) or quotient sign (div)
   logic               neg_hi_q;   // remainder sign (div only)
   logic [WIDTH-1:0]   opnd_q;     // multiplicand (mul) or divisor (div)
   logic [2*WIDTH-1:0] acc_q;      // mul: {partial, multiplier}; div: {rem, quo}
   logic [WIDTH-1:0]   hi_q;
   logic [WIDTH-1:0]   lo_q;
   logic               busy_q;
   logic               done_q;

   logic               sgn_op;
   logic               div_op;
   logic [WIDTH-1:0]   abs_a;
   logic [WIDTH-1:0]   abs_b;
   logic [WIDTH:0]     mul_sum;
   logic [2*WIDTH-1:0] mul_next;
   logic [WIDTH-1:0]   div_rem;
   logic [WIDTH-1:0]   div_quo;
   logic [2*WIDTH-1:0] fix_prod;
   logic [WIDTH-1:0]   fix_quo;
   logic [WIDTH-1:0]   fix_rem;

   always_comb begin
      sgn_op = op_is_signed(bus.op);
      div_op = op_is_div(bus.op);
      // The most negative value maps onto itself, which is its correct
      // unsigned magnitude, so 0x80..0 / -1 needs no special handling.
      abs_a  = (sgn_op && bus.a[MSB]) ? -bus.a : bus.a;
      abs_b  = (sgn_op && bus.b[MSB]) ? -bus.b : bus.b;
   end

   // Shift-add step: add the multiplicand to the upper half when the current
   // multiplier bit is set, then shift the whole accumulator right by one.
   always_comb begin
      mul_sum  = {1'b0, acc_q[2*WIDTH-1:WIDTH]} +
                 {1'b0, (acc_q[0] ? opnd_q : {WIDTH{1'b0}})};
      mul_next = {mul_sum, acc_q[WIDTH-1:1]};
   end

   div_core #(.WIDTH(WIDTH)) u_div_core (
      .rem_in  (acc_q[2*WIDTH-1:WIDTH]),
      .quo_in  (acc_q[WIDTH-1:0]),
      .dvs     (opnd_q),
      .rem_out (div_rem),
      .quo_out (div_quo)
   );

   always_comb begin
      fix_prod = neg_lo_q ? -acc_q : acc_q;
      fix_quo  = neg_lo_q ? -acc_q[WIDTH-1:0] : acc_q[WIDTH-1:0];
      fix_rem  = neg_hi_q ? -acc_q[2*WIDTH-1:WIDTH] : acc_q[2*WIDTH-1:WIDTH];
   end

`ifdef MULDIV_FAST_MUL_EN
   logic [2*WIDTH-1:0] ext_a;
   logic [2*WIDTH-1:0] ext_b;
   logic [2*WIDTH-1:0] fast_prod;

   // Low 2*WIDTH bits of the product of the extended operands are exact for
   // both the signed and the unsigned case.
   always_comb begin
      ext_a     = {{WIDTH{sgn_op & bus.a[MSB]}}, bus.a};
      ext_b     = {{WIDTH{sgn_op & bus.b[MSB]}}, bus.b};
      fast_prod = ext_a * ext_b;
   end
`endif

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state    <= IDLE;
         cnt      <= '0;
         is_div_q <= 1'b0;
         neg_lo_q <= 1'b0;
         neg_hi_q <= 1'b0;
         opnd_q   <= '0;
         acc_q    <= '0;
         hi_q     <= '0;
         lo_q     <= '0;
         busy_q   <= 1'b0;
         done_q   <= 1'b0;
      end else begin
         done_q <= 1'b0;
         if (bus.flush) begin
            // Squash: abandon any op, leave HI/LO untouched.
            state  <= IDLE;
            busy_q <= 1'b0;
            cnt    <= '0;
         end else begin
            case (state)
               IDLE: begin
                  if (bus.start) begin
                     if (div_op && (bus.b == '0)) begin
                        lo_q   <= '1;
                        hi_q   <= bus.a;
                        done_q <= 1'b1;
                     end
`ifdef MULDIV_FAST_MUL_EN
                     else if (!div_op) begin
                        {hi_q, lo_q} <= fast_prod;
                        done_q       <= 1'b1;
                     end
`endif
                     else begin
                        is_div_q <= div_op;
                        neg_lo_q <= sgn_op & (bus.a[MSB] ^ bus.b[MSB]);
                        neg_hi_q <= sgn_op & div_op & bus.a[MSB];
                        opnd_q   <= div_op ? abs_b : abs_a;
                        acc_q    <= div_op ? {{WIDTH{1'b0}}, abs_a}
                                           : {{WIDTH{1'b0}}, abs_b};
                        cnt      <= '0;
                        busy_q   <= 1'b1;
                        state    <= RUN;
                     end
                  end else begin
                     if (bus.mthi) hi_q <= bus.a;
                     if (bus.mtlo) lo_q <= bus.a;
                  end
               end
               RUN: begin
                  acc_q <= is_div_q ? {div_rem, div_quo} : mul_next;
                  cnt   <= cnt + 1'b1;
                  if (cnt == CNT_LAST) state <= FIX;
               end
               FIX: begin
                  if (is_div_q) begin
                     lo_q <= fix_quo;
                     hi_q <= fix_rem;
                  end else begin
                     {hi_q, lo_q} <= fix_prod;
                  end
                  busy_q <= 1'b0;
                  done_q <= 1'b1;
                  cnt    <= '0;
                  state  <= IDLE;
               end
               default: begin
                  busy_q <= 1'b0;
                  state  <= IDLE;
               end
            endcase
         end
      end
   end

   assign bus.hi    = hi_q;
   assign bus.lo    = lo_q;
   assign bus.busy  = busy_q;
   assign bus.done  = done_q;
   assign dbg_state = state;

endmodule
